register_bank_ram: RTL
======================

REGISTER_BANK_RAM -- requirements
Module: register_bank_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of one register.
REQ-002 SHALL have parameter BANK_BITS, default 4, giving 2^BANK_BITS register banks.
REQ-003 SHALL have parameter REG_BITS, default 4, giving 2^REG_BITS registers per bank; REG_BITS >= 1.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port bank  input  BANK_BITS  bank used by all read, write and clear_bank operations.
REQ-007 SHALL have port rd_en  input  1  read request.
REQ-008 SHALL have port rd_pair  input  1  read request is a register pair; sampled with rd_en.
REQ-009 SHALL have port rd_reg  input  REG_BITS  register index to read.
REQ-010 SHALL have port rd_data  output  2*DATA_WIDTH  registered read result.
REQ-011 SHALL have port rd_valid  output  1  rd_data holds the result of a request accepted on the previous cycle.
REQ-012 SHALL have port wr_en  input  1  byte write request.
REQ-013 SHALL have port wr_reg  input  REG_BITS  register index to write.
REQ-014 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-015 SHALL have port clear_bank  input  1  one-cycle request to zero every register of the bank on port bank.
REQ-016 SHALL have port busy  output  1  clear sequencer active; read and write requests ignored.

Function
REQ-017 SHALL store 2^(BANK_BITS+REG_BITS) words of DATA_WIDTH bits; physical address = {bank, reg}.
REQ-018 SHALL, on an accepted write (wr_en=1, busy=0), update location {bank, wr_reg} with wr_data at that edge.
REQ-019 SHALL, on an accepted byte read (rd_en=1, rd_pair=0, busy=0), load rd_data = {DATA_WIDTH zeros, mem[{bank, rd_reg}]} and set rd_valid=1 at the next edge (latency 1).
REQ-020 SHALL, on an accepted pair read (rd_pair=1), load rd_data = {mem[{bank, rd_reg with bit0=0}], mem[{bank, rd_reg with bit0=1}]}: even register high byte, odd register low byte.
REQ-021 SHALL, when a read and a write are accepted in the same cycle to the same location, return the new wr_data for that byte (write-first bypass); the other byte of a pair is unaffected.
REQ-022 SHALL clear rd_valid to 0 on any cycle with no accepted read; rd_data SHALL hold its last value.
REQ-023 SHALL implement a clear sequencer with states IDLE, CLEAR_ALL, CLEAR_BANK and a REG_BITS+BANK_BITS bit index counter.
REQ-024 SHALL move IDLE -> CLEAR_BANK on clear_bank=1, latching bank; it SHALL zero one register per cycle, index 0 upward, and return to IDLE after writing index 2^REG_BITS-1.
REQ-025 SHALL in CLEAR_ALL zero one location per cycle from address 0 upward and return to IDLE after the last address.
REQ-026 SHALL assert busy exactly while in CLEAR_ALL or CLEAR_BANK; with default parameters busy lasts 256 cycles for CLEAR_ALL and 16 for CLEAR_BANK.
REQ-027 SHALL ignore rd_en, wr_en and clear_bank while busy=1; an ignored read SHALL produce rd_valid=0.
REQ-028 SHALL give clear_bank priority over rd_en and wr_en in the same IDLE cycle, so those requests are ignored.
REQ-029 SHALL let bank change freely while CLEAR_BANK runs without affecting the latched bank being cleared.

Reset
REQ-030 SHALL, while reset=1 at a rising edge, set rd_data=0, rd_valid=0, counter=0 and enter CLEAR_ALL, so busy=1 on the following cycle.
REQ-031 SHALL, on reset asserted mid-clear, restart CLEAR_ALL from address 0.
REQ-032 SHALL make memory contents all zero once busy first deasserts after reset.

Verification
REQ-033 SHALL cover: reset 1 cycle, then idle -> busy=1 for exactly 256 cycles, then byte reads of all 256 locations return 0.
REQ-034 SHALL cover: bank=3, write reg 4=0x12 and reg 5=0x34, then pair read reg 5 -> rd_data=0x1234, rd_valid=1 one cycle later.
REQ-035 SHALL cover: bank=2, same-cycle write reg 7=0xA5 and byte read reg 7 -> rd_data=0x00A5.
REQ-036 SHALL cover: fill banks 1 and 2 with 0xFF, clear_bank with bank=1, change bank to 2 mid-clear -> busy 16 cycles; bank 1 all 0x00, bank 2 all 0xFF.
REQ-037 SHALL cover: wr_en with 0x55 and rd_en while busy -> location unchanged, rd_valid=0.
REQ-038 SHALL cover: reset asserted at clear index 100 -> busy remains 1 for 256 further cycles; all locations read 0 afterwards.

Source files
------------

// File: rtl/register_bank_ram_if.sv
// register_bank_ram_if: request/response bus of the banked register RAM
interface register_bank_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_BITS  = 4,
  parameter int REG_BITS   = 4
);
  logic [BANK_BITS-1:0]    bank;
  logic                    rd_en;
  logic                    rd_pair;
  logic [REG_BITS-1:0]     rd_reg;
  logic [2*DATA_WIDTH-1:0] rd_data;
  logic                    rd_valid;
  logic                    wr_en;
  logic [REG_BITS-1:0]     wr_reg;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    clear_bank;
  logic                    busy;
  modport master (
    output bank, rd_en, rd_pair, rd_reg, wr_en, wr_reg, wr_data, clear_bank,
    input  rd_data, rd_valid, busy
  );
  modport slave (
    input  bank, rd_en, rd_pair, rd_reg, wr_en, wr_reg, wr_data, clear_bank,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/register_bank_ram.sv
// register_bank_ram: banked byte registers with pair reads, write-first bypass and a clear sequencer
module register_bank_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_BITS  = 4,
  parameter int REG_BITS   = 4
) (
  input logic clock,
  input logic reset,
  register_bank_ram_if.slave bus
);
  localparam int AW = BANK_BITS + REG_BITS;
  typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_BANK} state_t;
  state_t state, state_n;
  logic [AW-1:0] idx, clr_addr;
  logic [BANK_BITS-1:0] clr_bank;
  logic [DATA_WIDTH-1:0] mem [1<<AW];
  logic rd_ok, wr_ok, last;
  logic [REG_BITS-1:0] ev, od;
  logic [DATA_WIDTH-1:0] ev_q, od_q, by_q;
  always_comb begin
    rd_ok = state == IDLE && bus.rd_en && !bus.clear_bank;
    wr_ok = state == IDLE && bus.wr_en && !bus.clear_bank;
    ev = bus.rd_reg & ~REG_BITS'(1);
    od = bus.rd_reg | REG_BITS'(1);
    ev_q = wr_ok && bus.wr_reg == ev ? bus.wr_data : mem[{bus.bank, ev}];
    od_q = wr_ok && bus.wr_reg == od ? bus.wr_data : mem[{bus.bank, od}];
    by_q = bus.rd_reg[0] ? od_q : ev_q;
    // a bank clear walks only the register bits of the counter
    clr_addr = state == CLEAR_BANK ? {clr_bank, idx[REG_BITS-1:0]} : idx;
    last = state == CLEAR_BANK ? &idx[REG_BITS-1:0] : &idx;
    state_n = state == IDLE ? (bus.clear_bank ? CLEAR_BANK : IDLE) : (last ? IDLE : state);
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR_ALL;
      idx <= '0;
      bus.rd_data <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      state <= state_n;
      idx <= state == IDLE ? '0 : idx + 1'b1;
      if (state == IDLE && bus.clear_bank) clr_bank <= bus.bank;
      bus.rd_valid <= rd_ok;
      if (rd_ok) bus.rd_data <= bus.rd_pair ? {ev_q, od_q} : {{DATA_WIDTH{1'b0}}, by_q};
    end
  end
  always_ff @(posedge clock) begin
    if (state != IDLE) mem[clr_addr] <= '0;
    else if (wr_ok) mem[{bus.bank, bus.wr_reg}] <= bus.wr_data;
  end
endmodule
